// File: rtl/matmul_mem_responder_if.sv
// Bus bundle between the matmul accelerator / host and the memory responder.
// master drives requests and host strobes; slave is the responder itself.
interface matmul_mem_responder_if #(
  parameter int DATA_BW = 32,
  parameter int ADDR_W  = 8
);
  // accelerator request channel
  logic [1:0]         mem_operation;
  logic [31:0]        addr_i;
  logic [DATA_BW-1:0] data_i;
  logic [DATA_BW-1:0] data_o;
  logic               mem_opdone;
  // host side-port
  logic               host_we;
  logic               host_re;
  logic [ADDR_W-1:0]  host_addr;
  logic [DATA_BW-1:0] host_wdata;
  logic [DATA_BW-1:0] host_rdata;
  logic               host_ready;
  // status
  logic               err;

  modport master (
    output mem_operation, addr_i, data_i,
    output host_we, host_re, host_addr, host_wdata,
    input  data_o, mem_opdone, host_rdata, host_ready, err
  );

  modport slave (
    input  mem_operation, addr_i, data_i,
    input  host_we, host_re, host_addr, host_wdata,
    output data_o, mem_opdone, host_rdata, host_ready, err
  );
endinterface

// File: rtl/matmul_mem_responder.sv
// Word-addressed memory model answering matmul accelerator requests with a
// fixed request-to-done latency, plus a host side-port usable while idle.
// Optional macro MATMEM_STATS_EN adds rd_count/wr_count transaction counters.
module matmul_mem_responder #(
  parameter int DATA_BW = 32,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  matmul_mem_responder_if.slave bus
`ifdef MATMEM_STATS_EN
  ,
  output logic [31:0]           rd_count,
  output logic [31:0]           wr_count
`endif
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] BUSY_LAST = 4'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_ILL  = 2'b10;
  localparam logic [1:0] OP_WR   = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  // Accelerator addresses are 32-bit; only the low ADDR_W bits index storage.
  function automatic logic addr_in_range(input logic [31:0] a);
    return (a >> ADDR_W) == 32'd0;
  endfunction

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               enter_resp;

  logic [1:0]         op_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               inrange_q;
  logic [DATA_BW-1:0] wdata_q;

  logic [DATA_BW-1:0] data_o_q, data_o_d;
  logic [DATA_BW-1:0] host_rdata_q, host_rdata_d;
  logic               err_q, err_d;

  logic [DATA_BW-1:0] mem_q [DEPTH];

  logic               accept;
  logic               host_ok;
  logic               host_wr_acc;
  logic               host_rd_acc;

  logic [1:0]         cur_op;
  logic [ADDR_W-1:0]  cur_addr;
  logic               cur_inrange;

  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [DATA_BW-1:0] mem_wdata;

  // The host port only gets the array when the accelerator is silent and idle.
  assign accept      = (state_q == IDLE) && (bus.mem_operation != OP_NONE);
  assign host_ok     = reset && (state_q == IDLE) && (bus.mem_operation == OP_NONE);
  assign host_wr_acc = host_ok && bus.host_we;
  assign host_rd_acc = host_ok && bus.host_re && !bus.host_we;

  // With LATENCY=1 the response is set up straight from IDLE, before the
  // request registers hold anything, so select live or latched request fields.
  always_comb begin
    if (state_q == IDLE) begin
      cur_op      = bus.mem_operation;
      cur_addr    = bus.addr_i[ADDR_W-1:0];
      cur_inrange = addr_in_range(bus.addr_i);
    end else begin
      cur_op      = op_q;
      cur_addr    = addr_q;
      cur_inrange = inrange_q;
    end
  end

  // State and latency counter register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: BUSY lasts LATENCY-1 cycles, RESPOND exactly one.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = 4'd0;
          if (LATENCY == 1) begin
            state_d    = RESPOND;
            enter_resp = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == BUSY_LAST) begin
          state_d    = RESPOND;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESPOND: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Capture the request on acceptance so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q      <= bus.mem_operation;
      addr_q    <= bus.addr_i[ADDR_W-1:0];
      inrange_q <= addr_in_range(bus.addr_i);
      wdata_q   <= bus.data_i;
    end
  end

  // Read data and error flag are prepared on the edge entering RESPOND so
  // they are already valid during the done pulse.
  always_comb begin
    data_o_d     = data_o_q;
    err_d        = err_q;
    host_rdata_d = host_rdata_q;
    if (enter_resp) begin
      if ((cur_op == OP_ILL) || !cur_inrange) begin
        err_d = 1'b1;
      end
      if (cur_op == OP_RD) begin
        data_o_d = cur_inrange ? mem_q[cur_addr] : '0;
      end
    end
    if (host_wr_acc && (bus.host_addr == '1) && bus.host_wdata[0]) begin
      err_d = 1'b0;
    end
    if (host_rd_acc) begin
      host_rdata_d = mem_q[bus.host_addr];
    end
  end

  // Output data and sticky error registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_o_q     <= '0;
      host_rdata_q <= '0;
      err_q        <= 1'b0;
    end else begin
      data_o_q     <= data_o_d;
      host_rdata_q <= host_rdata_d;
      err_q        <= err_d;
    end
  end

  // Single array write port: accelerator writes commit at the end of RESPOND,
  // host writes only while idle, so the two never collide.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if ((state_q == RESPOND) && (op_q == OP_WR) && inrange_q) begin
      mem_we    = 1'b1;
      mem_waddr = addr_q;
      mem_wdata = wdata_q;
    end else if (host_wr_acc) begin
      mem_we    = 1'b1;
      mem_waddr = bus.host_addr;
      mem_wdata = bus.host_wdata;
    end
  end

  // Storage array; contents survive reset, but a write pending at a reset
  // edge is discarded so an aborted transaction leaves no trace.
  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.mem_opdone = reset && (state_q == RESPOND);
  assign bus.data_o     = data_o_q;
  assign bus.host_rdata = host_rdata_q;
  assign bus.host_ready = host_ok && (bus.host_we || bus.host_re);
  assign bus.err        = err_q;

`ifdef MATMEM_STATS_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;

  // Count legal in-range transactions in their done cycle; wraps naturally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else if ((state_q == RESPOND) && inrange_q) begin
      if (op_q == OP_RD) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (op_q == OP_WR) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

endmodule

// File: doc/matmul_mem_responder.md
MATMUL_MEM_RESPONDER -- requirements
Module: matmul_mem_responder

Interface
REQ-001 SHALL have parameter DATA_BW, default 32, giving the word width; it equals the accelerator's `TYPE_BW.
REQ-002 SHALL have parameter ADDR_W, default 8, giving storage depth as 2^ADDR_W words.
REQ-003 SHALL have parameter LATENCY, default 2, legal range 1..15, giving request-to-mem_opdone cycles.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; low means reset.
REQ-006 mem_operation  input  2  01 = read, 11 = write, 00 = none, 10 = illegal.
REQ-007 addr_i  input  32  word address of the request.
REQ-008 data_i  input  DATA_BW  write data.
REQ-009 data_o  output  DATA_BW  read data.
REQ-010 mem_opdone  output  1  one-cycle completion pulse.
REQ-011 host_we, host_re  input  1 each  host write strobe and host read strobe.
REQ-012 host_addr  input  ADDR_W  host word address.
REQ-013 host_wdata  input  DATA_BW  host write data.
REQ-014 host_rdata  output  DATA_BW  host read data.
REQ-015 host_ready  output  1  high when a host access is accepted this cycle.
REQ-016 err  output  1  sticky error flag.

Function
REQ-017 FSM states SHALL be IDLE, BUSY, RESPOND.
- IDLE -> BUSY when mem_operation != 00.
- BUSY -> RESPOND after LATENCY-1 cycles in BUSY.
- RESPOND -> IDLE unconditionally.
REQ-018 On leaving IDLE, the block SHALL latch mem_operation, addr_i and data_i; later changes to these inputs SHALL be ignored until the next IDLE.
REQ-019 If the request is seen in IDLE during cycle c, mem_opdone SHALL be high during cycle c+LATENCY only, for exactly one cycle.
REQ-020 Read: data_o SHALL be valid in the mem_opdone cycle and SHALL hold until the next read completes.
REQ-021 Write: the array update SHALL commit at the clock edge that ends the mem_opdone cycle.
REQ-022 Back-to-back requests (mem_operation still non-zero with a new addr_i in the cycle after the pulse) SHALL be accepted from IDLE in that cycle, with no lost or duplicated transaction.
REQ-023 Out-of-range address (addr_i >= 2^ADDR_W): a read SHALL return 0, a write SHALL be dropped; err SHALL be set; mem_opdone SHALL still pulse.
REQ-024 mem_operation = 10: no array access; err SHALL be set; mem_opdone SHALL still pulse.
REQ-025 Host accesses SHALL be served only in IDLE with mem_operation == 00.
- host_ready = that condition AND (host_we OR host_re).
- If both host_we and host_re are high, the write SHALL win.
- Accelerator requests have priority; a host strobe that is not accepted SHALL have no effect.
REQ-026 host_rdata SHALL be registered and valid in the cycle after an accepted host_re; an out-of-range host address is impossible by width.
REQ-027 err SHALL be cleared only by reset or by an accepted host write to address all-ones with host_wdata bit0 = 1; that write also updates the array normally.

Reset
REQ-028 While reset is low at a clock edge, the block SHALL:
- go to IDLE;
- force mem_opdone = 0, data_o = 0, host_rdata = 0, err = 0, host_ready = 0;
- clear the latency counter.
REQ-029 Array contents SHALL be unaffected by reset.
REQ-030 Reset asserted during BUSY or RESPOND SHALL abort the transaction: no pulse and no write commit.

Configuration
REQ-031 Macro MATMEM_STATS_EN SHALL control transaction statistics.
- Defined: add outputs rd_count[31:0] and wr_count[31:0], reset to 0; each increments on a completed legal in-range read/write (mem_opdone cycle) and wraps at 2^32.
- Undefined: these ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-032 Host writes 3,2,2,3 to addresses 0..3, then a read at addr 1 (mem_operation = 01) is held -> mem_opdone pulses exactly at c+2 with data_o = 2 (LATENCY = 2).
REQ-033 Streamed reads of addresses 0..4 with mem_operation held at 01 and the address advanced on each pulse -> five pulses, data 3,2,2,3,x, no duplicates.
REQ-034 Write 0xDEAD to addr 10 with data_i changed to 0 after acceptance -> a host read of addr 10 returns 0xDEAD.
REQ-035 Read of addr 0x300 with ADDR_W = 8 -> data_o = 0, err = 1, and a pulse occurs; a host write of 1 to 0xFF clears err.
REQ-036 reset low mid-BUSY of a write to addr 5 -> no mem_opdone and addr 5 unchanged; host_we during an active request -> host_ready = 0 and no array change.
